// File: rtl/psram_pkg.sv
// Shared types for the PSRAM request bridge: posted-write record and bridge FSM states.
package psram_pkg;

    localparam int unsigned PS_AW = 25;

    typedef struct packed {
        logic [PS_AW-1:0] addr;
        logic [31:0]      data;
        logic [3:0]       be;
    } ps_wr_t;

    localparam int unsigned WR_W = $bits(ps_wr_t);

    typedef enum logic [1:0] {
        IDLE,
        WR_CMD,
        RD_CMD,
        RD_WAIT
    } bridge_state_e;

    // A posted write with no byte lanes enabled carries nothing to store.
    function automatic logic wr_has_bytes(input ps_wr_t w);
        return |w.be;
    endfunction

endpackage

// File: rtl/psram_wfifo.sv
// Posted-write FIFO: registered full/empty, pointers carry an extra wrap bit.
module psram_wfifo
    import psram_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic            clk100m,
    input  logic            rst_n,
    input  logic            push,
    input  logic [WR_W-1:0] wdata,
    input  logic            pop,
    output logic [WR_W-1:0] rdata,
    output logic            full,
    output logic            empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WR_W-1:0] mem [DEPTH];
    logic [AW:0]     wptr_q;
    logic [AW:0]     rptr_q;
    logic            do_push;
    logic            do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Same slot index with opposite wrap bits means the writer lapped the reader.
    assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    assign empty = (wptr_q == rptr_q);
    assign rdata = mem[rptr_q[AW-1:0]];

    always_ff @(posedge clk100m or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk100m) begin
        if (do_push) begin
            mem[wptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/psram_bus_bridge.sv
// Request-bus to ps_* command bridge: posted writes through a FIFO, one blocking read,
// and an idle-driven refresh hint.
module psram_bus_bridge
    import psram_pkg::*;
#(
    parameter int unsigned WFIFO_DEPTH  = 4,
    parameter int unsigned REFRESH_IDLE = 8
) (
    input  logic        clk100m,
    input  logic        rst_n,
    input  logic        bus_valid,
    output logic        bus_ready,
    input  logic        bus_we,
    input  logic [24:0] bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic [3:0]  bus_wbe,
    output logic        bus_rvalid,
    output logic [31:0] bus_rdata,
    output logic [24:0] ps_addr,
    output logic        ps_re,
    output logic        ps_we,
    output logic [31:0] ps_wdata,
    output logic [3:0]  ps_wbe,
    output logic        ps_refresh,
    input  logic        ps_cmdready,
    input  logic [31:0] ps_rdata,
    input  logic        ps_rdready
);

    localparam logic [7:0] IDLE_MAX = 8'(REFRESH_IDLE);

    bridge_state_e state_q, state_d;

    logic [24:0] ps_addr_q, ps_addr_d;
    logic [31:0] ps_wdata_q, ps_wdata_d;
    logic [3:0]  ps_wbe_q, ps_wbe_d;
    logic        ps_we_q, ps_we_d;
    logic        ps_re_q, ps_re_d;
    logic        rd_pend_q, rd_pend_d;
    logic [24:0] rd_addr_q, rd_addr_d;
    logic [31:0] bus_rdata_q, bus_rdata_d;
    logic        bus_rvalid_q, bus_rvalid_d;
    logic [7:0]  idle_cnt_q, idle_cnt_d;
    logic        refresh_q, refresh_d;

    logic            wf_full;
    logic            wf_empty;
    logic            wf_push;
    logic            wf_pop;
    logic [WR_W-1:0] wf_in_raw;
    logic [WR_W-1:0] wf_head_raw;
    ps_wr_t          wf_in;
    ps_wr_t          wf_head;
    logic            bus_accept;
    logic            idle_cond;

    // A pending read blocks all new requests so reads never overtake queued writes.
    assign bus_ready  = bus_we ? (!wf_full && !rd_pend_q) : !rd_pend_q;
    assign bus_accept = bus_valid && bus_ready;
    assign wf_push    = bus_accept && bus_we;

    assign wf_in       = '{addr: bus_addr, data: bus_wdata, be: bus_wbe};
    assign wf_in_raw   = wf_in;
    assign wf_head     = ps_wr_t'(wf_head_raw);

    psram_wfifo #(
        .DEPTH (WFIFO_DEPTH)
    ) u_wfifo (
        .clk100m (clk100m),
        .rst_n   (rst_n),
        .push    (wf_push),
        .wdata   (wf_in_raw),
        .pop     (wf_pop),
        .rdata   (wf_head_raw),
        .full    (wf_full),
        .empty   (wf_empty)
    );

    always_comb begin
        state_d      = state_q;
        ps_addr_d    = ps_addr_q;
        ps_wdata_d   = ps_wdata_q;
        ps_wbe_d     = ps_wbe_q;
        ps_we_d      = ps_we_q;
        ps_re_d      = ps_re_q;
        rd_pend_d    = rd_pend_q;
        rd_addr_d    = rd_addr_q;
        bus_rdata_d  = bus_rdata_q;
        bus_rvalid_d = 1'b0;
        wf_pop       = 1'b0;

        if (bus_accept && !bus_we) begin
            rd_pend_d = 1'b1;
            rd_addr_d = bus_addr;
        end

        unique case (state_q)
            IDLE: begin
                if (!wf_empty) begin
                    wf_pop = 1'b1;
                    if (wr_has_bytes(wf_head)) begin
                        ps_addr_d  = wf_head.addr;
                        ps_wdata_d = wf_head.data;
                        ps_wbe_d   = wf_head.be;
                        ps_we_d    = 1'b1;
                        state_d    = WR_CMD;
                    end
                end else if (rd_pend_q) begin
                    ps_addr_d = rd_addr_q;
                    ps_re_d   = 1'b1;
                    state_d   = RD_CMD;
                end
            end
            WR_CMD: begin
                if (ps_cmdready) begin
                    ps_we_d = 1'b0;
                    state_d = IDLE;
                end
            end
            RD_CMD: begin
                if (ps_cmdready) begin
                    ps_re_d = 1'b0;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (ps_rdready) begin
                    bus_rdata_d  = ps_rdata;
                    bus_rvalid_d = 1'b1;
                    rd_pend_d    = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Refresh hint: saturating count of fully quiet cycles.
    always_comb begin
        idle_cond = (state_q == IDLE) && wf_empty && !rd_pend_q && !bus_valid;
        if (!idle_cond) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q == IDLE_MAX) begin
            idle_cnt_d = idle_cnt_q;
        end else begin
            idle_cnt_d = idle_cnt_q + 8'd1;
        end
        refresh_d = (idle_cnt_d == IDLE_MAX);
    end

    always_ff @(posedge clk100m or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ps_addr_q    <= '0;
            ps_wdata_q   <= '0;
            ps_wbe_q     <= '0;
            ps_we_q      <= 1'b0;
            ps_re_q      <= 1'b0;
            rd_pend_q    <= 1'b0;
            rd_addr_q    <= '0;
            bus_rdata_q  <= '0;
            bus_rvalid_q <= 1'b0;
            idle_cnt_q   <= '0;
            refresh_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ps_addr_q    <= ps_addr_d;
            ps_wdata_q   <= ps_wdata_d;
            ps_wbe_q     <= ps_wbe_d;
            ps_we_q      <= ps_we_d;
            ps_re_q      <= ps_re_d;
            rd_pend_q    <= rd_pend_d;
            rd_addr_q    <= rd_addr_d;
            bus_rdata_q  <= bus_rdata_d;
            bus_rvalid_q <= bus_rvalid_d;
            idle_cnt_q   <= idle_cnt_d;
            refresh_q    <= refresh_d;
        end
    end

    assign ps_addr    = ps_addr_q;
    assign ps_wdata   = ps_wdata_q;
    assign ps_wbe     = ps_wbe_q;
    assign ps_we      = ps_we_q;
    assign ps_re      = ps_re_q;
    assign ps_refresh = refresh_q;
    assign bus_rdata  = bus_rdata_q;
    assign bus_rvalid = bus_rvalid_q;

endmodule
